// File: rtl/mux_scan.sv
// mux_scan
//
// N-channel, WIDTH-bit multiplexer with a registered output and two ways of
// choosing the channel:
//   - manual:    the channel comes from sel_in (out-of-range values are ignored)
//   - auto-scan: a prescaler dwells PRESCALE cycles on each channel, then
//                steps to the next one, wrapping N-1 -> 0
// Typical use is digit scanning for a multiplexed 7-segment display, where
// onehot drives the digit enables and q drives the segment decoder.
//
// Parameters
//   WIDTH     data bits per channel (>=1)
//   N         number of input channels (>=2)
//   PRESCALE  clk cycles spent on each channel in auto mode (>=1)
//
// Ports
//   clk     in   1            system clock, rising edge
//   rst_n   in   1            asynchronous active-low reset
//   d       in   N*WIDTH      packed channels, channel k = d[k*WIDTH +: WIDTH]
//   mode    in   1            0 = manual (sel_in), 1 = auto-scan
//   sel_in  in   $clog2(N)    manual channel select
//   en      in   1            1 = channel/prescaler may advance, 0 = freeze
//   q       out  WIDTH        registered data of the current channel
//   sel_q   out  $clog2(N)    registered index of the current channel
//   onehot  out  N            registered one-hot of the current channel
//   tick    out  1            one-cycle pulse when auto-scan advances

module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int N        = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*WIDTH-1:0]     d,
    input  logic                   mode,
    input  logic [$clog2(N)-1:0]   sel_in,
    input  logic                   en,
    output logic [WIDTH-1:0]       q,
    output logic [$clog2(N)-1:0]   sel_q,
    output logic [N-1:0]           onehot,
    output logic                   tick
);

    localparam int SEL_W = $clog2(N);
    // A prescale of 1 still needs a one-bit counter so the compare is legal.
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] CH_MAX  = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [N-1:0]     ONE     = {{(N-1){1'b0}}, 1'b1};

    // Reject configurations that make no sense at elaboration time.
    generate
        if (N < 2 || WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
            $error("mux_scan: requires N>=2, WIDTH>=1, PRESCALE>=1");
        end
    endgenerate

    logic [SEL_W-1:0] ch;
    logic [SEL_W-1:0] ch_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             tick_n;

    // Unpack the flat channel bus so the output mux is a plain array index.
    logic [WIDTH-1:0] chan [N];

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_unpack
            assign chan[k] = d[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Next-channel and prescaler decision. Freezing (en=0) holds both the
    // channel and the dwell count so a scan resumes exactly where it paused.
    // Manual mode clears the count so a later switch to auto starts a full
    // dwell on the manually chosen channel.
    always_comb begin
        ch_n   = ch;
        cnt_n  = cnt;
        tick_n = 1'b0;
        if (en) begin
            if (!mode) begin
                // Indices >= N only exist when N is not a power of two.
                if ({1'b0, sel_in} < N_EXT) begin
                    ch_n = sel_in;
                end
                cnt_n = '0;
            end else if (cnt == CNT_MAX) begin
                cnt_n  = '0;
                tick_n = 1'b1;
                ch_n   = (ch == CH_MAX) ? '0 : ch + 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // All outputs are loaded from ch_n on the same edge, so q, sel_q and
    // onehot always describe one channel. q is reloaded every cycle, which
    // lets it follow d even while the channel is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch     <= '0;
            cnt    <= '0;
            q      <= '0;
            sel_q  <= '0;
            onehot <= '0;
            tick   <= 1'b0;
        end else begin
            ch     <= ch_n;
            cnt    <= cnt_n;
            q      <= chan[ch_n];
            sel_q  <= ch_n;
            onehot <= ONE << ch_n;
            tick   <= tick_n;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan
//
// Directed bench for mux_scan using three instances:
//   u_a  N=4, WIDTH=4, PRESCALE=3  (reset, manual, auto, freeze)
//   u_b  N=3, WIDTH=4, PRESCALE=3  (out-of-range manual select)
//   u_c  N=4, WIDTH=4, PRESCALE=1  (mode switching with per-cycle scan)

module tb_mux_scan;

    logic clk;
    logic rst_n;

    logic [15:0] a_d;
    logic        a_mode, a_en;
    logic [1:0]  a_sel;
    logic [3:0]  a_q;
    logic [1:0]  a_selq;
    logic [3:0]  a_onehot;
    logic        a_tick;

    logic [11:0] b_d;
    logic        b_mode, b_en;
    logic [1:0]  b_sel;
    logic [3:0]  b_q;
    logic [1:0]  b_selq;
    logic [2:0]  b_onehot;
    logic        b_tick;

    logic [15:0] c_d;
    logic        c_mode, c_en;
    logic [1:0]  c_sel;
    logic [3:0]  c_q;
    logic [1:0]  c_selq;
    logic [3:0]  c_onehot;
    logic        c_tick;

    int passed = 0;
    int total  = 0;

    mux_scan #(.WIDTH(4), .N(4), .PRESCALE(3)) u_a (
        .clk(clk), .rst_n(rst_n), .d(a_d), .mode(a_mode), .sel_in(a_sel),
        .en(a_en), .q(a_q), .sel_q(a_selq), .onehot(a_onehot), .tick(a_tick)
    );

    mux_scan #(.WIDTH(4), .N(3), .PRESCALE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .d(b_d), .mode(b_mode), .sel_in(b_sel),
        .en(b_en), .q(b_q), .sel_q(b_selq), .onehot(b_onehot), .tick(b_tick)
    );

    mux_scan #(.WIDTH(4), .N(4), .PRESCALE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .d(c_d), .mode(c_mode), .sel_in(c_sel),
        .en(c_en), .q(c_q), .sel_q(c_selq), .onehot(c_onehot), .tick(c_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset while the clock is low so no edge coincides with release.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_mode = 1'b0; a_en = 1'b1; a_sel = 2'd2; a_d = 16'hDCBA;
        step();
        total++;
        if (a_selq !== 2'd2) $display("[TB] FAIL reset_pre_sel: got %0d expected 2", a_selq);
        else passed++;
        total++;
        if (a_q !== 4'hC) $display("[TB] FAIL reset_pre_q: got %h expected c", a_q);
        else passed++;
        // Assert reset between edges; outputs must clear without any clock.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (a_q !== 4'h0) $display("[TB] FAIL reset_q: got %h expected 0", a_q);
        else passed++;
        total++;
        if (a_selq !== 2'd0) $display("[TB] FAIL reset_sel: got %0d expected 0", a_selq);
        else passed++;
        total++;
        if (a_onehot !== 4'b0000) $display("[TB] FAIL reset_onehot: got %b expected 0000", a_onehot);
        else passed++;
        total++;
        if (a_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", a_tick);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [3:0] exp_q  [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        a_mode = 1'b0; a_en = 1'b1; a_d = 16'hDCBA;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            step();
            total++;
            if (a_q !== exp_q[i]) $display("[TB] FAIL manual_q%0d: got %h expected %h", i, a_q, exp_q[i]);
            else passed++;
            total++;
            if (a_onehot !== exp_oh[i]) $display("[TB] FAIL manual_onehot%0d: got %b expected %b", i, a_onehot, exp_oh[i]);
            else passed++;
            total++;
            if (a_selq !== 2'(i)) $display("[TB] FAIL manual_sel%0d: got %0d expected %0d", i, a_selq, i);
            else passed++;
        end
    endtask

    task automatic test_auto();
        logic [1:0] exp_sel [13] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                     2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        logic       exp_tk  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] nib [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [3:0] oh;
        a_mode = 1'b1; a_en = 1'b1; a_d = 16'hDCBA;
        pulse_reset();
        total++;
        if (a_selq !== 2'd0) $display("[TB] FAIL auto_start_sel: got %0d expected 0", a_selq);
        else passed++;
        for (int i = 0; i < 13; i++) begin
            step();
            oh = 4'b0001 << exp_sel[i];
            total++;
            if (a_selq !== exp_sel[i]) $display("[TB] FAIL auto_sel%0d: got %0d expected %0d", i, a_selq, exp_sel[i]);
            else passed++;
            total++;
            if (a_tick !== exp_tk[i]) $display("[TB] FAIL auto_tick%0d: got %b expected %b", i, a_tick, exp_tk[i]);
            else passed++;
            total++;
            if (a_q !== nib[exp_sel[i]]) $display("[TB] FAIL auto_q%0d: got %h expected %h", i, a_q, nib[exp_sel[i]]);
            else passed++;
            total++;
            if (a_onehot !== oh) $display("[TB] FAIL auto_onehot%0d: got %b expected %b", i, a_onehot, oh);
            else passed++;
        end
    endtask

    // Continues from test_auto: channel 0 with one cycle of its dwell used.
    task automatic test_freeze();
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) a_d = 16'h1234;
            step();
            total++;
            if (a_selq !== 2'd0) $display("[TB] FAIL freeze_sel%0d: got %0d expected 0", i, a_selq);
            else passed++;
            total++;
            if (a_tick !== 1'b0) $display("[TB] FAIL freeze_tick%0d: got %b expected 0", i, a_tick);
            else passed++;
            total++;
            if (a_q !== ((i < 2) ? 4'hA : 4'h4))
                $display("[TB] FAIL freeze_q%0d: got %h expected %h", i, a_q, (i < 2) ? 4'hA : 4'h4);
            else passed++;
        end
        a_en = 1'b1;
        step();
        total++;
        if (a_selq !== 2'd0 || a_tick !== 1'b0)
            $display("[TB] FAIL resume_hold: got sel %0d tick %b expected sel 0 tick 0", a_selq, a_tick);
        else passed++;
        step();
        total++;
        if (a_selq !== 2'd1 || a_tick !== 1'b1)
            $display("[TB] FAIL resume_adv: got sel %0d tick %b expected sel 1 tick 1", a_selq, a_tick);
        else passed++;
        total++;
        if (a_q !== 4'h3) $display("[TB] FAIL resume_q: got %h expected 3", a_q);
        else passed++;
        step();
        total++;
        if (a_tick !== 1'b0) $display("[TB] FAIL resume_tick_low: got %b expected 0", a_tick);
        else passed++;
    endtask

    task automatic test_n3_range();
        b_mode = 1'b0; b_en = 1'b1; b_d = 12'h987;
        b_sel = 2'd1;
        step();
        total++;
        if (b_q !== 4'h8 || b_selq !== 2'd1)
            $display("[TB] FAIL n3_load1: got q %h sel %0d expected q 8 sel 1", b_q, b_selq);
        else passed++;
        b_sel = 2'd3;
        step();
        total++;
        if (b_q !== 4'h8 || b_selq !== 2'd1)
            $display("[TB] FAIL n3_hold: got q %h sel %0d expected q 8 sel 1", b_q, b_selq);
        else passed++;
        total++;
        if (b_onehot !== 3'b010) $display("[TB] FAIL n3_hold_onehot: got %b expected 010", b_onehot);
        else passed++;
        b_sel = 2'd2;
        step();
        total++;
        if (b_q !== 4'h9 || b_selq !== 2'd2)
            $display("[TB] FAIL n3_load2: got q %h sel %0d expected q 9 sel 2", b_q, b_selq);
        else passed++;
        total++;
        if (b_onehot !== 3'b100) $display("[TB] FAIL n3_onehot2: got %b expected 100", b_onehot);
        else passed++;
    endtask

    task automatic test_mode_switch();
        logic [1:0] exp_sel [6] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_tk  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_q   [6] = '{4'hB, 4'hC, 4'hB, 4'hC, 4'hD, 4'hA};
        c_d = 16'hDCBA; c_en = 1'b1; c_sel = 2'd1;
        for (int i = 0; i < 6; i++) begin
            c_mode = (i == 2) ? 1'b0 : 1'b1;
            step();
            total++;
            if (c_selq !== exp_sel[i]) $display("[TB] FAIL switch_sel%0d: got %0d expected %0d", i, c_selq, exp_sel[i]);
            else passed++;
            total++;
            if (c_tick !== exp_tk[i]) $display("[TB] FAIL switch_tick%0d: got %b expected %b", i, c_tick, exp_tk[i]);
            else passed++;
            total++;
            if (c_q !== exp_q[i]) $display("[TB] FAIL switch_q%0d: got %h expected %h", i, c_q, exp_q[i]);
            else passed++;
        end
        total++;
        if (c_onehot !== 4'b0001) $display("[TB] FAIL switch_onehot_wrap: got %b expected 0001", c_onehot);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_d = '0; a_mode = 1'b0; a_en = 1'b0; a_sel = '0;
        b_d = '0; b_mode = 1'b0; b_en = 1'b0; b_sel = '0;
        c_d = '0; c_mode = 1'b0; c_en = 1'b0; c_sel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset");
        test_reset();
        $display("[TB] manual select");
        test_manual();
        $display("[TB] auto scan");
        test_auto();
        $display("[TB] freeze");
        test_freeze();
        $display("[TB] N=3 range");
        test_n3_range();
        $display("[TB] mode switch");
        test_mode_switch();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
